// File: rtl/btn_pkg.sv
// Shared button-path constants: state encoding and default timing.
// Reused by the debouncer, btn_repeat and the game controller.
package btn_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

  // 0.25 s initial delay and 0.1 s repeat period at 100 MHz
  localparam int unsigned BTN_DELAY_CYC  = 25_000_000;
  localparam int unsigned BTN_REPEAT_CYC = 10_000_000;
  localparam int unsigned BTN_CNT_W      = 25;

endpackage

// File: rtl/btn_tc_counter.sv
// Up-counter with synchronous clear/increment and terminal-count compare
// against a runtime limit.
module btn_tc_counter #(
  parameter int unsigned CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == limit);

endmodule

// File: rtl/btn_repeat.sv
// Press/auto-repeat generator for one debounced button.
// Define BTN_REPEAT_ACCEL_EN to halve the repeat period after 8 repeats.
//
// state  | meaning
// IDLE   | button released, waiting for a press
// HOLD   | pressed, counting the initial delay
// REPEAT | long press, emitting periodic repeat pulses
module btn_repeat
  import btn_pkg::*;
#(
  parameter int unsigned DELAY_CYC  = BTN_DELAY_CYC,
  parameter int unsigned REPEAT_CYC = BTN_REPEAT_CYC,
  parameter int unsigned CNT_W      = BTN_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clean,
  input  logic enable,
  output logic pulse,
  output logic held,
  output logic release_pulse  // "release" is a reserved word
);

  localparam logic [CNT_W-1:0] DLY_LIM = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_LIM = CNT_W'(REPEAT_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic             pulse_q, pulse_d;
  logic             held_q, held_d;
  logic             rel_q, rel_d;
  logic             cnt_clr, cnt_inc, cnt_tc;
  logic [CNT_W-1:0] cnt_lim, rpt_lim;

`ifdef BTN_REPEAT_ACCEL_EN
  localparam int unsigned ACC_CYC = ((REPEAT_CYC >> 1) < 1) ? 1 : (REPEAT_CYC >> 1);
  localparam logic [CNT_W-1:0] ACC_LIM = CNT_W'(ACC_CYC - 1);

  logic [3:0] rpt_n_q, rpt_n_d;

  assign rpt_lim = (rpt_n_q >= 4'd8) ? ACC_LIM : RPT_LIM;

  // counts repeat pulses of the current press, saturating at 15
  always_comb begin
    rpt_n_d = rpt_n_q;
    if (state_d != REPEAT) begin
      rpt_n_d = '0;
    end else if (pulse_d && (rpt_n_q != 4'hF)) begin
      rpt_n_d = rpt_n_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rpt_n_q <= '0;
    end else begin
      rpt_n_q <= rpt_n_d;
    end
  end
`else
  assign rpt_lim = RPT_LIM;
`endif

  assign cnt_lim = (state_q == HOLD) ? DLY_LIM : rpt_lim;

  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    rel_d   = 1'b0;
    held_d  = held_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      held_d  = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_clr = 1'b1;
          if (clean) begin
            state_d = HOLD;
            pulse_d = 1'b1;
          end
        end
        HOLD, REPEAT: begin
          // release takes priority over a terminal count in the same cycle
          if (!clean) begin
            state_d = IDLE;
            rel_d   = 1'b1;
            held_d  = 1'b0;
            cnt_clr = 1'b1;
          end else if (cnt_tc) begin
            state_d = REPEAT;
            pulse_d = 1'b1;
            held_d  = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          held_d  = 1'b0;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pulse_q <= 1'b0;
      held_q  <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      held_q  <= held_d;
      rel_q   <= rel_d;
    end
  end

  btn_tc_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .limit(cnt_lim),
    .tc   (cnt_tc)
  );

  assign pulse         = pulse_q;
  assign held          = held_q;
  assign release_pulse = rel_q;

endmodule

// File: tb/tb_btn_repeat.sv
// Directed bench for btn_repeat with DELAY_CYC=8, REPEAT_CYC=4, CNT_W=4.
// Each check compares {pulse, held, release_pulse} right after an edge.
module tb_btn_repeat;

  logic clk = 1'b0;
  logic rst;
  logic clean;
  logic enable;
  logic pulse;
  logic held;
  logic release_pulse;

  int n_cmp = 0;
  int n_err = 0;

  btn_repeat #(
    .DELAY_CYC (8),
    .REPEAT_CYC(4),
    .CNT_W     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clean        (clean),
    .enable       (enable),
    .pulse        (pulse),
    .held         (held),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  // inputs set before the call are sampled at this edge; outputs read 1 ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] exp;
    logic [2:0] obs;
    rst = 1'b1; clean = 1'b1; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {pulse, held, release_pulse};
      n_cmp++;
      if (obs !== 3'b000) begin
        n_err++;
        $display("FAIL reset_hold cyc %0d: got %b want 000", i, obs);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clean = (i == 0);
      step();
      exp = {(i == 0), 1'b0, (i == 1)};
      obs = {pulse, held, release_pulse};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL reset_release cyc %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_short_press();
    logic [2:0] exp;
    logic [2:0] obs;
    for (int i = 0; i < 8; i++) begin
      clean = (i < 5);
      step();
      exp = {(i == 0), 1'b0, (i == 5)};
      obs = {pulse, held, release_pulse};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL short_press cyc %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_long_press(input string name);
    logic [2:0] exp;
    logic [2:0] obs;
    for (int i = 0; i < 23; i++) begin
      clean = (i < 20);
      step();
      exp = {(i == 0 || i == 8 || i == 12 || i == 16),
             (i >= 8 && i < 20),
             (i == 20)};
      obs = {pulse, held, release_pulse};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL %s cyc %0d: got %b want %b", name, i, obs, exp);
      end
    end
  endtask

  task automatic test_coincident_release();
    logic [2:0] exp;
    logic [2:0] obs;
    for (int i = 0; i < 11; i++) begin
      clean = (i < 8);
      step();
      exp = {(i == 0), 1'b0, (i == 8)};
      obs = {pulse, held, release_pulse};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL coincident_release cyc %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_enable();
    logic [2:0] exp;
    logic [2:0] obs;
    for (int i = 0; i < 17; i++) begin
      clean  = (i < 14);
      enable = !(i >= 10 && i < 13);
      step();
      exp = {(i == 0 || i == 8 || i == 13),
             (i == 8 || i == 9),
             (i == 14)};
      obs = {pulse, held, release_pulse};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL enable_drop cyc %0d: got %b want %b", i, obs, exp);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_mid_reset();
    logic [2:0] exp;
    logic [2:0] obs;
    for (int i = 0; i < 14; i++) begin
      clean = (i < 12);
      rst   = (i == 10);
      step();
      exp = {(i == 0 || i == 8 || i == 11),
             (i == 8 || i == 9),
             (i == 12)};
      obs = {pulse, held, release_pulse};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL mid_reset cyc %0d: got %b want %b", i, obs, exp);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_long_hold();
    logic [2:0] exp;
    logic [2:0] obs;
    logic       exp_p;
    for (int i = 0; i < 63; i++) begin
      clean = (i < 60);
`ifdef BTN_REPEAT_ACCEL_EN
      exp_p = (i == 0) ||
              (i >= 8 && i <= 36 && ((i - 8) % 4 == 0)) ||
              (i > 36 && i < 60 && (i % 2 == 0));
`else
      exp_p = (i == 0) || (i >= 8 && i < 60 && ((i - 8) % 4 == 0));
`endif
      step();
      exp = {exp_p, (i >= 8 && i < 60), (i == 60)};
      obs = {pulse, held, release_pulse};
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL long_hold cyc %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; clean = 1'b0; enable = 1'b1;
    test_reset();
    test_short_press();
    test_long_press("long_press");
    test_coincident_release();
    test_enable();
    test_mid_reset();
    test_long_hold();
    test_long_press("back_to_back");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
